// File: rtl/af_sweep_ctrl.sv
// Autofocus sweep sequencer: steps the VCM lens position across a range,
// measures one sharpness sample per step after settling, tracks the best
// position, then writes that best position back to the VCM.
module af_sweep_ctrl #(
    parameter logic [9:0]  POS_MIN       = 10'd0,
    parameter logic [9:0]  POS_MAX       = 10'd1023,
    parameter logic [9:0]  STEP          = 10'd64,
    parameter logic [3:0]  SETTLE_FRAMES = 4'd2,
    parameter logic [3:0]  VCM_MODE      = 4'h0,
    parameter logic [23:0] ACK_TIMEOUT   = 24'd5000000
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        ABORT,
    input  logic        FRAME_END,
    input  logic [31:0] FOCUS_VALUE,
    output logic [15:0] VCM_DATA,
    output logic        VCM_REQ,
    input  logic        VCM_ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic [9:0]  BEST_POS,
    output logic [31:0] BEST_VALUE,
    output logic        TIMEOUT_ERR
);

    localparam int unsigned POS_W  = 10;
    localparam int unsigned SUM_W  = POS_W + 1;
    localparam int unsigned VAL_W  = 32;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned TO_W   = 24;
    localparam int unsigned FRM_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT_ACK,
        S_SETTLE,
        S_MEASURE,
        S_NEXT,
        S_FINAL_WRITE,
        S_FINAL_ACK
    } state_t;

    state_t              r_state;
    logic [POS_W-1:0]    r_pos;
    logic [POS_W-1:0]    r_best_pos;
    logic [VAL_W-1:0]    r_best_value;
    logic [WORD_W-1:0]   r_vcm_data;
    logic                r_vcm_req;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout_err;
    logic [TO_W-1:0]     r_to_cnt;
    logic [FRM_W-1:0]    r_frm_cnt;

    logic [SUM_W-1:0]    w_sum;
    logic                w_frame;
    logic                w_to_hit;
    logic                w_settle_last;

    // VCM command word for a given lens position
    function automatic logic [WORD_W-1:0] vcm_word(input logic [POS_W-1:0] pos);
        return {2'b00, pos, VCM_MODE};
    endfunction

    // Next candidate position (one extra bit so overshoot is detectable)
    assign w_sum         = SUM_W'(r_pos) + SUM_W'(STEP);
    // A frame coinciding with an ACK is not counted
    assign w_frame       = FRAME_END & ~VCM_ACK;
    assign w_to_hit      = (r_to_cnt == ACK_TIMEOUT - TO_W'(1));
    assign w_settle_last = (r_frm_cnt == SETTLE_FRAMES - FRM_W'(1));

    // Sweep sequencer with registered outputs
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= S_IDLE;
            r_pos         <= POS_MIN;
            r_best_pos    <= POS_MIN;
            r_best_value  <= '0;
            r_vcm_data    <= vcm_word(POS_MIN);
            r_vcm_req     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_to_cnt      <= '0;
            r_frm_cnt     <= '0;
        end else begin
            r_vcm_req <= 1'b0;
            r_done    <= 1'b0;
            if (ABORT && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (START && !ABORT) begin
                            r_pos         <= POS_MIN;
                            r_best_pos    <= POS_MIN;
                            r_best_value  <= '0;
                            r_timeout_err <= 1'b0;
                            r_busy        <= 1'b1;
                            r_vcm_data    <= vcm_word(POS_MIN);
                            r_vcm_req     <= 1'b1;
                            r_state       <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        r_to_cnt <= '0;
                        r_state  <= S_WAIT_ACK;
                    end
                    S_WAIT_ACK: begin
                        if (VCM_ACK) begin
                            r_frm_cnt <= '0;
                            r_state   <= S_SETTLE;
                        end else if (w_to_hit) begin
                            r_timeout_err <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (SETTLE_FRAMES == FRM_W'(0)) begin
                            r_state <= S_MEASURE;
                        end else if (w_frame) begin
                            if (w_settle_last) begin
                                r_state <= S_MEASURE;
                            end else begin
                                r_frm_cnt <= r_frm_cnt + FRM_W'(1);
                            end
                        end
                    end
                    S_MEASURE: begin
                        if (w_frame) begin
                            if (FOCUS_VALUE > r_best_value) begin
                                r_best_value <= FOCUS_VALUE;
                                r_best_pos   <= r_pos;
                            end
                            r_state <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (w_sum > SUM_W'(POS_MAX)) begin
                            r_vcm_data <= vcm_word(r_best_pos);
                            r_vcm_req  <= 1'b1;
                            r_state    <= S_FINAL_WRITE;
                        end else begin
                            r_pos      <= w_sum[POS_W-1:0];
                            r_vcm_data <= vcm_word(w_sum[POS_W-1:0]);
                            r_vcm_req  <= 1'b1;
                            r_state    <= S_WRITE;
                        end
                    end
                    S_FINAL_WRITE: begin
                        r_to_cnt <= '0;
                        r_state  <= S_FINAL_ACK;
                    end
                    S_FINAL_ACK: begin
                        if (VCM_ACK) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (w_to_hit) begin
                            r_timeout_err <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign VCM_DATA    = r_vcm_data;
    assign VCM_REQ     = r_vcm_req;
    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign BEST_POS    = r_best_pos;
    assign BEST_VALUE  = r_best_value;
    assign TIMEOUT_ERR = r_timeout_err;

endmodule

// File: tb/tb_af_sweep_ctrl.sv
// Bench for af_sweep_ctrl: randomized sweeps checked against a list-based
// model of the expected positions and the best-value selection.
module tb_af_sweep_ctrl;

    localparam logic [9:0]  P_MIN    = 10'd0;
    localparam logic [9:0]  P_MAX    = 10'd255;
    localparam logic [9:0]  P_STEP   = 10'd64;
    localparam logic [3:0]  P_SETTLE = 4'd2;
    localparam logic [3:0]  P_MODE   = 4'h0;
    localparam logic [23:0] P_TO     = 24'd1000;

    logic        CLK_50      = 1'b0;
    logic        RESET_N     = 1'b0;
    logic        START       = 1'b0;
    logic        ABORT       = 1'b0;
    logic        FRAME_END   = 1'b0;
    logic [31:0] FOCUS_VALUE = '0;
    logic        VCM_ACK     = 1'b0;
    logic [15:0] VCM_DATA;
    logic        VCM_REQ;
    logic        BUSY;
    logic        DONE;
    logic [9:0]  BEST_POS;
    logic [31:0] BEST_VALUE;
    logic        TIMEOUT_ERR;

    int n_chk = 0;
    int n_err = 0;
    int n_req = 0;
    int n_done = 0;
    int exp_pos[$];
    logic [31:0] vals[16];

    af_sweep_ctrl #(
        .POS_MIN(P_MIN), .POS_MAX(P_MAX), .STEP(P_STEP),
        .SETTLE_FRAMES(P_SETTLE), .VCM_MODE(P_MODE), .ACK_TIMEOUT(P_TO)
    ) u_dut (
        .CLK_50(CLK_50), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .FRAME_END(FRAME_END), .FOCUS_VALUE(FOCUS_VALUE), .VCM_DATA(VCM_DATA),
        .VCM_REQ(VCM_REQ), .VCM_ACK(VCM_ACK), .BUSY(BUSY), .DONE(DONE),
        .BEST_POS(BEST_POS), .BEST_VALUE(BEST_VALUE), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK_50 = ~CLK_50;

    // Pulse counters for requests and completions
    always @(posedge CLK_50) begin
        if (VCM_REQ === 1'b1) n_req++;
        if (DONE === 1'b1) n_done++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [15:0] word(input int p);
        return {2'b00, 10'(p), P_MODE};
    endfunction

    task automatic tick();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input string tag, output bit ok);
        int n = 0;
        while (VCM_REQ !== 1'b1 && n < 32) begin
            tick();
            n++;
        end
        ok = (VCM_REQ === 1'b1);
        chk_eq({tag, "_req_seen"}, 32'(ok), 32'd1);
    endtask

    // One step: REQ check, ACK after dly cycles in WAIT_ACK, then n_frm frames
    task automatic do_write(input int pos, input int dly, input logic [31:0] val,
                            input bit give_ack, input int n_frm);
        bit ok;
        wait_req("wr", ok);
        if (!ok) return;
        chk_eq("wr_word", 32'(VCM_DATA), 32'(word(pos)));
        chk_eq("wr_busy", 32'(BUSY), 32'd1);
        tick();
        chk_eq("req_one_cycle", 32'(VCM_REQ), 32'd0);
        for (int i = 0; i < dly; i++) begin
            FRAME_END   = ($urandom_range(0, 3) == 0);
            FOCUS_VALUE = $urandom;
            START       = ($urandom_range(0, 7) == 0);
            tick();
        end
        FRAME_END = 1'b0;
        START     = 1'b0;
        if (!give_ack) return;
        VCM_ACK     = 1'b1;
        FRAME_END   = 1'($urandom_range(0, 1));
        FOCUS_VALUE = 32'hFFFF_FFFF;
        tick();
        VCM_ACK   = 1'b0;
        FRAME_END = 1'b0;
        for (int f = 0; f < n_frm; f++) begin
            repeat ($urandom_range(0, 2)) tick();
            FRAME_END   = 1'b1;
            FOCUS_VALUE = (f == int'(P_SETTLE)) ? val : $urandom;
            tick();
            FRAME_END = 1'b0;
        end
    endtask

    // Full sweep over vals[]; dly<0 means random ACK delay per write
    task automatic run_sweep(input int dly, input bit rst_final);
        int bp = int'(P_MIN);
        logic [31:0] bv = '0;
        int d0 = n_done;
        int d;
        bit ok;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk_eq("req_latency", 32'(VCM_REQ), 32'd1);
        chk_eq("to_cleared", 32'(TIMEOUT_ERR), 32'd0);
        for (int i = 0; i < exp_pos.size(); i++) begin
            d = (dly < 0) ? int'($urandom_range(0, 12)) : dly;
            do_write(exp_pos[i], d, vals[i], 1'b1, int'(P_SETTLE) + 1);
            if (vals[i] > bv) begin
                bv = vals[i];
                bp = exp_pos[i];
            end
        end
        wait_req("final", ok);
        chk_eq("final_word", 32'(VCM_DATA), 32'(word(bp)));
        tick();
        if (rst_final) begin
            #2 RESET_N = 1'b0;
            #1;
            chk_eq("rst_data", 32'(VCM_DATA), 32'(word(int'(P_MIN))));
            chk_eq("rst_req", 32'(VCM_REQ), 32'd0);
            chk_eq("rst_busy", 32'(BUSY), 32'd0);
            chk_eq("rst_done", 32'(DONE), 32'd0);
            chk_eq("rst_best_pos", 32'(BEST_POS), 32'(P_MIN));
            chk_eq("rst_best_val", BEST_VALUE, 32'd0);
            chk_eq("rst_to", 32'(TIMEOUT_ERR), 32'd0);
            #1 RESET_N = 1'b1;
            tick();
            return;
        end
        repeat ($urandom_range(0, 10)) tick();
        VCM_ACK = 1'b1;
        tick();
        VCM_ACK = 1'b0;
        chk_eq("done_pulse", 32'(DONE), 32'd1);
        chk_eq("busy_after", 32'(BUSY), 32'd0);
        chk_eq("best_pos", 32'(BEST_POS), 32'(bp));
        chk_eq("best_val", BEST_VALUE, bv);
        tick();
        chk_eq("done_low", 32'(DONE), 32'd0);
        chk_eq("done_count", 32'(n_done - d0), 32'd1);
    endtask

    initial begin
        int r0;
        int dn0;
        logic [31:0] v0;

        for (int p = int'(P_MIN); p <= int'(P_MAX); p += int'(P_STEP)) exp_pos.push_back(p);

        // Reset state
        repeat (2) tick();
        chk_eq("reset_data", 32'(VCM_DATA), 32'(word(int'(P_MIN))));
        chk_eq("reset_busy", 32'(BUSY), 32'd0);
        chk_eq("reset_best", BEST_VALUE, 32'd0);
        chk_eq("reset_to", 32'(TIMEOUT_ERR), 32'd0);
        @(negedge CLK_50) RESET_N = 1'b1;
        tick();

        // Directed sweep with distinct values
        vals[0] = 32'd100; vals[1] = 32'd300; vals[2] = 32'd200; vals[3] = 32'd50;
        run_sweep(10, 1'b0);

        // Ties keep the earliest position
        for (int i = 0; i < 16; i++) vals[i] = 32'd500;
        run_sweep(-1, 1'b0);

        // Randomized sweeps, some with forced ties
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < 16; i++)
                vals[i] = (s % 2 == 0) ? 32'($urandom_range(0, 4)) * 32'd1000 : $urandom;
            run_sweep(-1, 1'b0);
        end

        // ACK on the last allowed cycle, then a withheld ACK times out
        START = 1'b1;
        tick();
        START = 1'b0;
        dn0 = n_done;
        do_write(exp_pos[0], int'(P_TO) - 1, 32'd7, 1'b1, int'(P_SETTLE) + 1);
        chk_eq("limit_ack_no_err", 32'(TIMEOUT_ERR), 32'd0);
        do_write(exp_pos[1], int'(P_TO) - 1, 32'd0, 1'b0, 0);
        chk_eq("to_before", 32'(TIMEOUT_ERR), 32'd0);
        chk_eq("to_busy_before", 32'(BUSY), 32'd1);
        tick();
        chk_eq("to_set", 32'(TIMEOUT_ERR), 32'd1);
        chk_eq("to_busy", 32'(BUSY), 32'd0);
        repeat (3) tick();
        chk_eq("to_no_done", 32'(n_done - dn0), 32'd0);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk_eq("to_clear", 32'(TIMEOUT_ERR), 32'd0);
        chk_eq("to_restart_req", 32'(VCM_REQ), 32'd1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk_eq("abort_write_busy", 32'(BUSY), 32'd0);

        // Abort during settle, followed by stray ACK and frame
        v0 = $urandom | 32'd1;
        START = 1'b1;
        tick();
        START = 1'b0;
        do_write(exp_pos[0], 3, v0, 1'b1, int'(P_SETTLE) + 1);
        do_write(exp_pos[1], 3, 32'd0, 1'b1, 1);
        ABORT = 1'b1;
        VCM_ACK = 1'b1;
        FRAME_END = 1'b1;
        tick();
        ABORT = 1'b0;
        VCM_ACK = 1'b0;
        FRAME_END = 1'b0;
        chk_eq("abort_busy", 32'(BUSY), 32'd0);
        r0 = n_req;
        dn0 = n_done;
        VCM_ACK = 1'b1;
        FRAME_END = 1'b1;
        FOCUS_VALUE = 32'hFFFF_FFFF;
        tick();
        VCM_ACK = 1'b0;
        FRAME_END = 1'b0;
        repeat (5) tick();
        chk_eq("abort_no_req", 32'(n_req - r0), 32'd0);
        chk_eq("abort_no_done", 32'(n_done - dn0), 32'd0);
        chk_eq("abort_best_pos", 32'(BEST_POS), 32'(exp_pos[0]));
        chk_eq("abort_best_val", BEST_VALUE, v0);
        chk_eq("abort_data", 32'(VCM_DATA), 32'(word(exp_pos[1])));

        // START and ABORT together from idle
        START = 1'b1;
        ABORT = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        chk_eq("sa_busy", 32'(BUSY), 32'd0);
        chk_eq("sa_req", 32'(VCM_REQ), 32'd0);
        tick();
        chk_eq("sa_req2", 32'(VCM_REQ), 32'd0);

        // Reset asserted during the final ACK wait, then a clean sweep
        for (int i = 0; i < 16; i++) vals[i] = $urandom;
        run_sweep(-1, 1'b1);
        for (int i = 0; i < 16; i++) vals[i] = $urandom;
        run_sweep(-1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/af_sweep_ctrl.md
Name: af_sweep_ctrl

Overview:
- Autofocus sweep sequencer that drives the VCM I2C write engine.
- Steps the 10-bit lens position from POS_MIN to POS_MAX and issues one VCM write per step.
- After each write, waits out settle frames, then samples one frame's sharpness metric and tracks the maximum.
- Ends by writing the best position back to the VCM, then reports it.

Parameters:
- POS_MIN, 10'd0, first sweep position
- POS_MAX, 10'd1023, last allowed position (inclusive)
- STEP, 10'd64, position increment per step (must be ≥1)
- SETTLE_FRAMES, 4'd2, frames discarded after each write before measuring
- VCM_MODE, 4'h0, constant placed in VCM word bits [3:0]
- ACK_TIMEOUT, 24'd5000000, CLK_50 cycles allowed for VCM_ACK per write

Ports:
- CLK_50  in  1  system clock, all logic on its rising edge
- RESET_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse; begins a sweep when idle
- ABORT  in  1  one-cycle pulse; cancels the sweep
- FRAME_END  in  1  one-cycle pulse at end of each frame
- FOCUS_VALUE  in  32  frame sharpness metric, valid when FRAME_END=1
- VCM_DATA  out  16  VCM word = {2'b00, POS[9:0], VCM_MODE}
- VCM_REQ  out  1  one-cycle write request to the I2C engine
- VCM_ACK  in  1  one-cycle pulse; I2C write of VCM_DATA completed
- BUSY  out  1  high from accepted START until return to IDLE
- DONE  out  1  one-cycle pulse after the final best-position write acks
- BEST_POS  out  10  position with the highest metric
- BEST_VALUE  out  32  that metric
- TIMEOUT_ERR  out  1  sticky; set on ACK timeout, cleared by next accepted START

Behaviour:
- Reset: state=IDLE, VCM_DATA={2'b00, POS_MIN, VCM_MODE}, VCM_REQ=0, BUSY=0, DONE=0, BEST_POS=POS_MIN, BEST_VALUE=0, TIMEOUT_ERR=0, all counters 0.
- IDLE: on START (and not ABORT), go to WRITE.
  - pos←POS_MIN, BEST_VALUE←0, BEST_POS←POS_MIN, TIMEOUT_ERR←0, BUSY←1.
  - START in any other state is ignored.
- WRITE: VCM_DATA updated from pos; VCM_REQ=1 for exactly this one cycle; next state WAIT_ACK, timeout counter←0.
- WAIT_ACK: on VCM_ACK go to SETTLE, frame counter←0.
  - If the counter reaches ACK_TIMEOUT-1 without ACK: TIMEOUT_ERR←1, BUSY←0, go to IDLE, no DONE.
  - An ACK arriving in the same cycle as the limit is accepted; no error.
- SETTLE: count FRAME_END pulses; after the SETTLE_FRAMES-th pulse go to MEASURE.
  - SETTLE_FRAMES=0 goes to MEASURE the next cycle.
- MEASURE: on the next FRAME_END, compare.
  - If FOCUS_VALUE > BEST_VALUE (unsigned, strict; ties keep the earlier position): BEST_VALUE←FOCUS_VALUE, BEST_POS←pos.
  - Next state NEXT.
- NEXT: compute 11-bit sum = pos + STEP.
  - If sum > POS_MAX: go to FINAL_WRITE.
  - Else pos←sum[9:0], go to WRITE.
  - Wrap-around never occurs.
- FINAL_WRITE: VCM_DATA from BEST_POS, VCM_REQ=1 one cycle, go to FINAL_ACK.
- FINAL_ACK: same ACK and timeout rule as WAIT_ACK.
  - On ACK: DONE=1 for one cycle, BUSY←0, go to IDLE.
- Latency: VCM_REQ asserts on the 2nd cycle after START (START cycle → WRITE).
- FRAME_END outside SETTLE/MEASURE is ignored. A FRAME_END in the same cycle as VCM_ACK is not counted.
- ABORT in any non-IDLE state: next state IDLE, BUSY←0, VCM_REQ=0.
  - No DONE; BEST_* and VCM_DATA hold their last values.
  - A late VCM_ACK afterwards is ignored.
  - ABORT has priority over START, VCM_ACK and FRAME_END in the same cycle.
- Sweep length = floor((POS_MAX-POS_MIN)/STEP)+1 writes, plus one final write.
- Reset mid-sweep returns all outputs to reset values immediately (asynchronous).

Test Plan:
1. Full sweep with POS_MIN=0, POS_MAX=255, STEP=64, SETTLE=2, ACK 10 cycles after each REQ, FOCUS_VALUE=100,300,200,50 per measured frame.
   - Required: REQ words 0x0000, 0x0400, 0x0800, 0x0C00, then final 0x0400; BEST_POS=64, BEST_VALUE=300; one DONE pulse; BUSY low after DONE.
2. Tie and boundary with POS_MAX=200, STEP=100, values 500,500,500.
   - Required: positions 0,100,200 written (sum=300>200 stops); BEST_POS=0.
3. Timeout: withhold VCM_ACK after the 2nd REQ, ACK_TIMEOUT=1000.
   - Required: TIMEOUT_ERR=1 at cycle 1000 after WAIT_ACK entry; BUSY=0; no DONE.
   - Then START clears TIMEOUT_ERR.
4. ABORT during SETTLE, then a stray VCM_ACK and FRAME_END.
   - Required: IDLE, no REQ, no DONE, BEST_* unchanged.
5. START+ABORT in the same cycle from IDLE.
   - Required: stays IDLE, BUSY=0.
   - START while BUSY does not restart pos.
6. Assert RESET_N low in FINAL_ACK.
   - Required: all outputs at reset values before the next clock edge.
